// File: rtl/mtm_alu_pkg.sv
// Shared constants for the mtm_Alu serial link: opcodes, frame layout,
// error flag positions, CRC polynomial and the receiver state encoding.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam int FRAME_LEN = 11;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CTL  = 1'b1;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // x^4 + x + 1 with the x^4 term implied by the shift
  localparam logic [3:0] CRC_POLY = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TYPE    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_STOP    = 3'd3,
    ST_REPORT  = 3'd4
  } rx_state_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mtm_alu_crc4_serial.sv
// One-bit-per-clock CRC-4 LFSR; clr reloads INIT and takes priority over en.
module mtm_alu_crc4_serial
  import mtm_alu_pkg::*;
#(
  parameter logic [3:0] INIT = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [3:0] crc
);

  logic [3:0] crc_q;
  logic [3:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = din ^ crc_q[3];
    crc_d = crc_q;
    if (clr) begin
      crc_d = INIT;
    end else if (en) begin
      crc_d = {crc_q[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/mtm_alu_rx_deser.sv
// Serial command receiver: deframes 11-bit frames on sin, gathers B then A,
// validates the CTL frame and pulses either op_valid or err_valid.
module mtm_alu_rx_deser
  import mtm_alu_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter logic [3:0] CRC_INIT = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [2:0]        op_out,
  output logic              op_valid,
  output logic              err_valid,
  output logic [2:0]        err_flags
);

  localparam int            NB       = DATA_W / 8;
  localparam int            CW       = $clog2(2 * NB + 2);
  localparam int            PAY_BITS = FRAME_LEN - 3;
  localparam logic [2:0]    PAY_LAST = 3'(PAY_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(2 * NB);
  localparam logic [CW-1:0] CNT_SAT  = CW'(2 * NB + 1);

  rx_state_e               state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic                    type_q, type_d;
  logic [6:0]              pay_q, pay_d;
  logic [2*DATA_W-1:0]     sr_q, sr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]       a_q, a_d, b_q, b_d;
  logic [2:0]              op_q, op_d;
  logic                    op_valid_q, op_valid_d;
  logic                    err_valid_q, err_valid_d;
  logic [2:0]              err_flags_q, err_flags_d;
  logic [2:0]              ctl_flags;
  logic                    crc_en, crc_clr, crc_din;
  logic [3:0]              crc;

  mtm_alu_crc4_serial #(.INIT(CRC_INIT)) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (crc_en),
    .clr   (crc_clr),
    .din   (crc_din),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!sin) state_d = ST_TYPE;
      ST_TYPE:    state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (bit_cnt_q == PAY_LAST) state_d = ST_STOP;
      ST_STOP:    state_d = (!sin || type_q == TYPE_CTL) ? ST_REPORT : ST_IDLE;
      // A start bit seen while reporting opens the next frame directly
      ST_REPORT:  state_d = sin ? ST_IDLE : ST_TYPE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // CTL verdict, evaluated against the fully shifted payload in STOP
  always_comb begin
    ctl_flags = '0;
    if (cnt_q != CNT_FULL) begin
      ctl_flags[ERR_DATA_BIT] = 1'b1;
    end else if (crc != pay_q[3:0]) begin
      ctl_flags[ERR_CRC_BIT] = 1'b1;
    end else if (!op_is_valid(pay_q[6:4])) begin
      ctl_flags[ERR_OP_BIT] = 1'b1;
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    type_d      = type_q;
    pay_d       = pay_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    op_valid_d  = 1'b0;
    err_valid_d = 1'b0;
    err_flags_d = err_flags_q;
    crc_en      = 1'b0;
    crc_clr     = 1'b0;
    crc_din     = sin;
    case (state_q)
      ST_TYPE: begin
        type_d    = sin;
        bit_cnt_d = '0;
      end
      ST_PAYLOAD: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        pay_d     = {pay_q[5:0], sin};
        if (type_q == TYPE_DATA) begin
          if (cnt_q < CNT_FULL) begin
            sr_d   = {sr_q[2*DATA_W-2:0], sin};
            crc_en = 1'b1;
          end
        end else if (bit_cnt_q < 3'd4) begin
          // CTL: the leading payload bit is replaced by the 1'b1 marker, then OP
          crc_en = 1'b1;
          if (bit_cnt_q == 3'd0) crc_din = 1'b1;
        end
      end
      ST_STOP: begin
        if (!sin) begin
          err_valid_d               = 1'b1;
          err_flags_d               = '0;
          err_flags_d[ERR_DATA_BIT] = 1'b1;
        end else if (type_q == TYPE_CTL) begin
          if (ctl_flags == 3'b000) begin
            op_valid_d = 1'b1;
            b_d        = sr_q[2*DATA_W-1:DATA_W];
            a_d        = sr_q[DATA_W-1:0];
            op_d       = pay_q[6:4];
          end else begin
            err_valid_d = 1'b1;
            err_flags_d = ctl_flags;
          end
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        cnt_d   = '0;
        sr_d    = '0;
        crc_clr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      type_q      <= TYPE_DATA;
      pay_q       <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      op_valid_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_flags_q <= '0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      type_q      <= type_d;
      pay_q       <= pay_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      err_valid_q <= err_valid_d;
      err_flags_q <= err_flags_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign op_valid  = op_valid_q;
  assign err_valid = err_valid_q;
  assign err_flags = err_flags_q;

endmodule

// File: tb/tb_mtm_alu_rx_deser.sv
// Bench for mtm_alu_rx_deser: a 32-bit and a 16-bit receiver, table-driven
// packets plus hand-built corner sequences, checked through expected queues.
module tb_mtm_alu_rx_deser;
  import mtm_alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin32 = 1'b1;
  logic sin16 = 1'b1;

  always #5 clk = ~clk;

  logic [31:0] a_out32, b_out32;
  logic [2:0]  op_out32, err_flags32;
  logic        op_valid32, err_valid32;
  logic [15:0] a_out16, b_out16;
  logic [2:0]  op_out16, err_flags16;
  logic        op_valid16, err_valid16;

  mtm_alu_rx_deser #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .sin(sin32),
    .a_out(a_out32), .b_out(b_out32), .op_out(op_out32),
    .op_valid(op_valid32), .err_valid(err_valid32), .err_flags(err_flags32)
  );

  mtm_alu_rx_deser #(.DATA_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sin(sin16),
    .a_out(a_out16), .b_out(b_out16), .op_out(op_out16),
    .op_valid(op_valid16), .err_valid(err_valid16), .err_flags(err_flags16)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        is_err;
    logic [2:0]  flags;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
  } exp_t;

  typedef struct {
    logic [63:0] b;
    logic [63:0] a;
    logic [2:0]  op;
    logic        use_ctl;
    logic [7:0]  ctl;
    logic [3:0]  crc_xor;
    logic [2:0]  exp_flags;
  } vec_t;

  exp_t        exp_q32[$];
  exp_t        exp_q16[$];
  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  int          pulses32 = 0;
  int          pulses16 = 0;
  logic [63:0] last_a[2];
  logic [63:0] last_b[2];
  logic [2:0]  last_op[2];
  logic [2:0]  ops[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_pulse(input string pfx, input exp_t e, input logic ov, input logic ev,
                           input logic [2:0] fl, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op);
    check({pfx, "_valid_pair"}, {62'd0, ov, ev}, e.is_err ? 64'd1 : 64'd2);
    check({pfx, "_a_out"}, a, e.a);
    check({pfx, "_b_out"}, b, e.b);
    check({pfx, "_op_out"}, 64'(op), 64'(e.op));
    if (e.is_err) check({pfx, "_err_flags"}, 64'(fl), 64'(e.flags));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (op_valid32 || err_valid32) begin
        pulses32++;
        if (exp_q32.size() == 0) begin
          check("dut32_unexpected_pulse", 64'd1, 64'd0);
        end else begin
          e = exp_q32.pop_front();
          cmp_pulse("dut32", e, op_valid32, err_valid32, err_flags32,
                    64'(a_out32), 64'(b_out32), op_out32);
        end
      end
      if (op_valid16 || err_valid16) begin
        pulses16++;
        if (exp_q16.size() == 0) begin
          check("dut16_unexpected_pulse", 64'd1, 64'd0);
        end else begin
          e = exp_q16.pop_front();
          cmp_pulse("dut16", e, op_valid16, err_valid16, err_flags16,
                    64'(a_out16), 64'(b_out16), op_out16);
        end
      end
    end
  end

  // CRC as polynomial remainder of {B, A, 1, OP} * x^4 modulo x^4 + x + 1
  function automatic logic [3:0] model_crc(input logic [63:0] b, input logic [63:0] a,
                                           input int w, input logic [2:0] op);
    logic msg[$];
    int   n;
    for (int i = w - 1; i >= 0; i--) msg.push_back(b[i]);
    for (int i = w - 1; i >= 0; i--) msg.push_back(a[i]);
    msg.push_back(1'b1);
    for (int i = 2; i >= 0; i--) msg.push_back(op[i]);
    repeat (4) msg.push_back(1'b0);
    n = msg.size();
    for (int i = 0; i < n - 4; i++) begin
      if (msg[i]) begin
        msg[i]     = 1'b0;
        msg[i + 3] = msg[i + 3] ^ 1'b1;
        msg[i + 4] = msg[i + 4] ^ 1'b1;
      end
    end
    return {msg[n - 4], msg[n - 3], msg[n - 2], msg[n - 1]};
  endfunction

  function automatic void push_exp(input int sel, input logic is_err, input logic [2:0] flags);
    exp_t e;
    e.is_err = is_err;
    e.flags  = flags;
    e.a      = last_a[sel];
    e.b      = last_b[sel];
    e.op     = last_op[sel];
    if (sel == 0) exp_q32.push_back(e);
    else          exp_q16.push_back(e);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_bit(input int sel, input logic b);
    if (sel == 0) sin32 = b;
    else          sin16 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic typ, input logic [7:0] data, input logic stop);
    send_bit(sel, 1'b0);
    send_bit(sel, typ);
    for (int i = 7; i >= 0; i--) send_bit(sel, data[i]);
    send_bit(sel, stop);
  endtask

  task automatic check_latency(input int sel);
    if (sel == 0) check("dut32_pulse_after_stop", 64'(op_valid32 | err_valid32), 64'd1);
    else          check("dut16_pulse_after_stop", 64'(op_valid16 | err_valid16), 64'd1);
  endtask

  task automatic send_packet(input int sel, input int w, input logic [63:0] b, input logic [63:0] a,
                             input logic [2:0] op, input logic use_ctl, input logic [7:0] ctl,
                             input logic [3:0] crc_xor, input logic [2:0] exp_flags);
    logic [7:0] cb;
    for (int k = w / 8 - 1; k >= 0; k--) send_frame(sel, TYPE_DATA, b[8*k +: 8], 1'b1);
    for (int k = w / 8 - 1; k >= 0; k--) send_frame(sel, TYPE_DATA, a[8*k +: 8], 1'b1);
    cb = use_ctl ? ctl : {1'b0, op, model_crc(b, a, w, op) ^ crc_xor};
    if (exp_flags == 3'b000) begin
      last_a[sel]  = a;
      last_b[sel]  = b;
      last_op[sel] = op;
      push_exp(sel, 1'b0, 3'b000);
    end else begin
      push_exp(sel, 1'b1, exp_flags);
    end
    send_frame(sel, TYPE_CTL, cb, 1'b1);
    check_latency(sel);
  endtask

  task automatic add_vec(input logic [63:0] b, input logic [63:0] a, input logic [2:0] op,
                         input logic use_ctl, input logic [7:0] ctl, input logic [3:0] crc_xor,
                         input logic [2:0] exp_flags);
    vec_t v;
    v.b = b; v.a = a; v.op = op; v.use_ctl = use_ctl; v.ctl = ctl;
    v.crc_xor = crc_xor; v.exp_flags = exp_flags;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs();
    check("rst_a_out32", 64'(a_out32), 64'd0);
    check("rst_b_out32", 64'(b_out32), 64'd0);
    check("rst_op_out32", 64'(op_out32), 64'd0);
    check("rst_valids32", 64'({op_valid32, err_valid32, err_flags32}), 64'd0);
    check("rst_a_out16", 64'(a_out16), 64'd0);
    check("rst_b_out16", 64'(b_out16), 64'd0);
    check("rst_valids16", 64'({op_valid16, err_valid16, err_flags16, op_out16}), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : main
    int p;
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_ADD; ops[3] = OP_SUB;
    for (int s = 0; s < 2; s++) begin
      last_a[s] = '0; last_b[s] = '0; last_op[s] = '0;
    end

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_outputs();

    // CRC of {B=2, A=5, 1, 100} is 4'b1011, so a CTL byte of 0x40 is a CRC error
    add_vec(64'd2, 64'd5, OP_ADD, 1'b0, 8'h00, 4'h0, 3'b000);
    add_vec(64'd2, 64'd5, OP_ADD, 1'b1, 8'h4B, 4'h0, 3'b000);
    add_vec(64'd2, 64'd5, OP_ADD, 1'b1, 8'h40, 4'h0, 3'b010);
    add_vec(64'd2, 64'd5, 3'b010, 1'b0, 8'h00, 4'h0, 3'b001);
    add_vec(64'd2, 64'd5, 3'b110, 1'b0, 8'h00, 4'h5, 3'b010);
    for (int i = 0; i < 4; i++) begin
      add_vec(64'hFFFF_FFFF, 64'h0, ops[i], 1'b0, 8'h00, 4'h0, 3'b000);
      add_vec(64'h0, 64'hFFFF_FFFF, ops[i], 1'b0, 8'h00, 4'h0, 3'b000);
    end
    add_vec(64'h1234_5678, 64'h9ABC_DEF0, OP_SUB, 1'b0, 8'h00, 4'h0, 3'b000);

    // Packets follow each other with the next start bit in the REPORT cycle
    foreach (vecs[i])
      send_packet(0, 32, vecs[i].b, vecs[i].a, vecs[i].op, vecs[i].use_ctl,
                  vecs[i].ctl, vecs[i].crc_xor, vecs[i].exp_flags);

    // Short packet: two DATA bytes then CTL
    send_frame(0, TYPE_DATA, 8'h55, 1'b1);
    send_frame(0, TYPE_DATA, 8'h0F, 1'b1);
    push_exp(0, 1'b1, 3'b100);
    send_frame(0, TYPE_CTL, 8'h50, 1'b1);
    check_latency(0);

    // Overrun: nine DATA bytes
    for (int k = 0; k < 9; k++) send_frame(0, TYPE_DATA, 8'(k * 17), 1'b1);
    push_exp(0, 1'b1, 3'b100);
    send_frame(0, TYPE_CTL, {1'b0, OP_ADD, 4'h0}, 1'b1);
    check_latency(0);

    // CTL with no DATA at all
    push_exp(0, 1'b1, 3'b100);
    send_frame(0, TYPE_CTL, 8'h40, 1'b1);
    check_latency(0);

    // Framing error on a DATA frame is reported at once and drops the packet
    send_frame(0, TYPE_DATA, 8'hAA, 1'b1);
    push_exp(0, 1'b1, 3'b100);
    send_frame(0, TYPE_DATA, 8'h3C, 1'b0);
    check_latency(0);
    send_bit(0, 1'b1);
    send_packet(0, 32, 64'd7, 64'd9, OP_SUB, 1'b0, 8'h00, 4'h0, 3'b000);

    for (int i = 0; i < 4; i++)
      send_packet(0, 32, 64'($urandom), 64'($urandom), ops[$urandom_range(0, 3)],
                  1'b0, 8'h00, 4'h0, 3'b000);

    // 16-bit receiver
    send_packet(1, 16, 64'hA5C3, 64'h0F0F, OP_ADD, 1'b0, 8'h00, 4'h0, 3'b000);
    send_packet(1, 16, 64'h00FF, 64'h1234, OP_AND, 1'b0, 8'h00, 4'h3, 3'b010);

    // Abort a packet with reset in the middle of a payload
    send_frame(1, TYPE_DATA, 8'h12, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, TYPE_DATA);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    #2 rst_n = 1'b0;
    sin16 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      last_a[s] = '0; last_b[s] = '0; last_op[s] = '0;
    end
    check_reset_outputs();
    p = pulses16;
    repeat (15) @(posedge clk);
    #1;
    check("dut16_no_pulse_after_abort", 64'(pulses16), 64'(p));

    send_packet(1, 16, 64'hBEEF, 64'h0042, OP_SUB, 1'b0, 8'h00, 4'h0, 3'b000);
    send_packet(1, 16, 64'hFFFF, 64'h0000, OP_OR, 1'b0, 8'h00, 4'h0, 3'b000);

    repeat (5) @(posedge clk);
    #1;
    check("dut32_pending_expected", 64'(exp_q32.size()), 64'd0);
    check("dut16_pending_expected", 64'(exp_q16.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtm_alu_rx_deser.md
Name: mtm_alu_rx_deser

Overview:
Parametrised serial command receiver for the mtm_Alu datapath. It deframes the 11-bit serial protocol on `sin`, collects B then A operands of DATA_W bits each, then a CTL frame. It checks frame count, CRC-4 and opcode, and presents either a validated operation or an error code to the ALU core. It generalises the fixed 32-bit receiver to any byte-multiple operand width and computes the CRC on the fly.

Parameters:
- DATA_W, 32, operand width in bits; must be a multiple of 8, range 8..64.
- NB, DATA_W/8, bytes per operand; derived, not overridable.
- CRC_INIT, 4'h0, CRC register value at the start of each packet.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- sin  in  1  serial input; idle high; one bit sampled per clk.
- a_out  out  DATA_W  operand A, MSB-first assembled.
- b_out  out  DATA_W  operand B.
- op_out  out  3  opcode from the CTL frame.
- op_valid  out  1  one-cycle pulse; a_out, b_out and op_out are valid.
- err_valid  out  1  one-cycle pulse; err_flags is valid.
- err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, byte counter is 0, CRC register is CRC_INIT. Reset is asynchronous and takes effect mid-frame; no partial result is emitted afterwards.
- Frame format (11 clk): start = 0, type (0 = DATA, 1 = CTL), payload[7:0] MSB first, stop = 1.
- FSM states:
  - IDLE → TYPE when `sin` = 0.
  - TYPE → PAYLOAD; the type bit is latched.
  - PAYLOAD: 8 bits are shifted in.
  - STOP: the stop bit is checked.
  - After STOP, the FSM returns to IDLE, or goes to REPORT if the frame was CTL or a framing error occurred.
  - REPORT: one cycle, then IDLE.
- DATA frame: the payload is shifted into a 2·DATA_W operand shift register. The first NB bytes form B, the next NB form A. The byte counter saturates at 2·NB+1.
- CRC:
  - Serial LFSR with polynomial x^4 + x + 1.
  - Advanced on each DATA payload bit while counter < 2·NB, then over 1'b1, then over the 3 CTL opcode bits.
  - Covers the sequence {B, A, 1'b1, OP}, first bit = MSB of B.
  - CTL payload = {1'b0, OP[2:0], CRC[3:0]}; the received CRC is compared with the computed CRC.
- Error detection at the CTL stop bit:
  - ERR_DATA: byte counter ≠ 2·NB, or the stop bit is 0 on any frame.
  - ERR_CRC: CRC mismatch.
  - ERR_OP: OP ∉ {000 AND, 001 OR, 100 ADD, 101 SUB}.
- Reporting:
  - Priority is ERR_DATA > ERR_CRC > ERR_OP; exactly one flag is set.
  - A framing error (stop = 0) reports ERR_DATA immediately and discards the packet.
- Latency:
  - op_valid or err_valid asserts on the clk after the CTL stop bit is sampled, for exactly 1 cycle.
  - a_out, b_out and op_out hold until the next op_valid; they are not updated on error.
- Packet boundary: after REPORT, the counter, shift register and CRC are cleared, and the next start bit may arrive in that same REPORT cycle. A start bit during REPORT is accepted with no lost cycle.
- Byte overrun: more than 2·NB DATA frames → extra bytes are ignored (no shift, no CRC update), and ERR_DATA is reported at the CTL frame.
- A CTL frame with zero preceding DATA frames → ERR_DATA.

Decomposition:
- mtm_alu_pkg:
  - opcode localparams AND/OR/ADD/SUB;
  - frame length 11;
  - type encodings DATA = 0, CTL = 1;
  - err_flags bit indices;
  - CRC polynomial constant 4'b0011.
- Sub-module mtm_alu_crc4_serial (en, clr, din, crc[3:0]): one-bit-per-clock LFSR, reused by the future transmitter.

Test Plan:
- DATA_W=32, B=2, A=5, OP=100, CTL byte = {0,100,model CRC} → op_valid pulse; a_out = 5, b_out = 2, op_out = 100.
- Same operands, CTL byte 0x40 (CRC 0000; the true CRC has bit0 = 1) → err_valid, err_flags = 010; a_out and b_out unchanged.
- DATA frames 0x55, 0x0F, then CTL 0x50 (2 of 8 bytes) → err_flags = 100, one cycle after the stop bit.
- Valid operands, OP = 010 with correct CRC → err_flags = 001.
- 0xFFFFFFFF and 0x00000000 operands, all four ops, back-to-back packets with start in REPORT cycle → 8 op_valid pulses with correct fields.
- DATA_W=16 build, plus rst_n low mid-PAYLOAD then a valid packet → no pulse from the aborted packet; the next packet decodes correctly.
